krv_uart_rx: RTL and testbench
==============================

// Module: krv_uart_rx
// PURPOSE
// - Serial receiver for the krv_c UART: recovers 8-bit frames from the UART_RX pad.
// - Counterpart of the UART transmitter that drives UART_TX.
// - Sits between the pad and the peripheral bus register file; buffers bytes in a small FIFO.
// - Flags framing and overrun errors.
// PARAMETERS
// - FIFO_DEPTH    4   RX FIFO entries; power of 2, >=2
// - OVERSAMPLE    16  baud ticks per bit; fixed mid-bit sample at tick OVERSAMPLE/2-1
// PORTS
// - cpu_clk      in   1   single clock; all state updates on rising edge
// - cpu_rst      in   1   synchronous, active-high reset
// - uart_rx      in   1   async serial input, idle high
// - baud_div     in   16  baud tick period = baud_div+1 cpu_clk cycles (0 -> tick every cycle)
// - rx_data      out  8   FIFO head byte; valid only while rx_valid=1
// - rx_valid     out  1   FIFO not empty
// - rx_ready     in   1   consumer pop; pop occurs when rx_valid & rx_ready
// - frame_err    out  1   sticky: stop bit sampled 0 (or parity bad, see CONFIGURATION)
// - overrun_err  out  1   sticky: completed byte dropped because FIFO full
// - err_clr      in   1   clears both sticky flags
// - rx_busy      out  1   FSM not in IDLE
// BEHAVIOUR
// - Reset: rx_valid=0, rx_data=0, frame_err=0, overrun_err=0, rx_busy=0.
//   FIFO pointers=0, FSM=IDLE, sync flops=1, baud counter=0.
// - Reset mid-frame aborts the frame and flushes the FIFO.
// - Sync: 2-flop synchronizer on uart_rx; FSM uses 2nd stage (rxs), plus registered rxs_d.
// - Baud tick: 16b counter counts to baud_div, pulses tick, reloads 0.
//   The counter restarts at 0 on start-edge detection.
// - FSM states and transitions:
//   - IDLE: arm only on falling edge (rxs_d=1, rxs=0) -> START, sample cnt=0.
//     A line held low after a break never re-arms until it returns high.
//   - START: at cnt=7 re-sample. If rxs=1 -> IDLE (glitch, no flag). Else cnt=0 -> DATA.
//   - DATA: sample every 16 ticks (cnt=15); shift in LSB first; after bit 7 -> PARITY or STOP.
//   - PARITY: present only with UART_RX_PARITY_EN; sample at cnt=15 -> STOP.
//   - STOP: sample at cnt=15 (mid stop bit), then -> IDLE the same cycle.
//     rxs=1 and parity ok -> push byte. Otherwise set frame_err and discard the byte.
// - Latency: rx_valid rises the cycle after the mid-stop sample; rx_data = byte same cycle.
// - FIFO: push on good stop. If full and no pop the same cycle -> drop and set overrun_err.
//   Full + pop + push in the same cycle -> both happen; no overrun.
//   Empty + push: pop not possible that cycle (rx_valid=0).
//   Pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSB differ, low bits equal.
// - rx_data stable while rx_valid=1 & rx_ready=0.
// - err_clr vs new error in the same cycle: the error wins (flag stays 1).
// - baud_div changes take effect at the next tick reload; mid-frame changes are unsupported.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: 8E1 frame, even parity.
//   Parity bit sampled after bit 7; (^data ^ parity)=1 -> frame_err, byte discarded.
// - Not defined: 8N1 frame; PARITY state and parity logic are absent.
// TESTING
// - Reset: baud_div=0, uart_rx=1, cpu_rst=1 for 3 cycles -> all outputs 0, rx_busy=0.
// - Single byte: baud_div=0, send 0xA5 8N1 at 16 clk/bit -> rx_valid rises 1 cycle after
//   mid-stop; rx_data=0xA5; rx_ready=1 pops and rx_valid -> 0.
// - Glitch: uart_rx low for 4 cycles then high (baud_div=0) -> START aborts to IDLE,
//   no push, no frame_err.
// - Frame error: send 0x3C with stop bit 0, then hold line high -> frame_err=1, rx_valid=0.
//   err_clr pulse -> frame_err=0. A following good 0x3C is received.
// - Overrun: rx_ready=0; send 0x01..0x05 -> bytes 1-4 stored, overrun_err=1, head=0x01.
//   Then send with rx_ready=1 during the mid-stop cycle of a byte arriving while full
//   -> accepted, no new overrun.
// - Parity (UART_RX_PARITY_EN): 0x07 with parity 1 -> stored.
//   0x07 with parity 0 -> frame_err=1, dropped.

Source files
------------

// File: rtl/krv_uart_rx.sv
// krv_uart_rx: 8N1 UART receiver with a small RX FIFO and sticky framing/overrun flags.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module krv_uart_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        uart_rx,
  input  logic [15:0] baud_div,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overrun_err,
  input  logic        err_clr,
  output logic        rx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] STOP = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  logic          s1_q, rxs_q, rxs_prev_q;
  logic [2:0]    state_q, state_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
  logic          tick, push, ferr_set, full, pop, do_push, par_ok;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_ok = ~(^sh_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif
  assign tick = bcnt_q == baud_div;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rx_valid = wp_q != rp_q;
  assign pop = rx_valid & rx_ready;
  assign do_push = push & (~full | pop);
  assign rx_data = rx_valid ? mem_q[rp_q[AW-1:0]] : 8'd0;
  assign frame_err = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    bcnt_d = tick ? 16'd0 : bcnt_q + 16'd1;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    push = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: if (rxs_prev_q & ~rxs_q) begin
        state_d = START;
        cnt_d = '0;
        bcnt_d = 16'd0;
      end
      START: if (tick) begin
        cnt_d = (cnt_q == MID) ? '0 : cnt_q + CW'(1);
        bit_d = 3'd0;
        if (cnt_q == MID) state_d = rxs_q ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sh_d = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          par_d = rxs_q;
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          push = rxs_q & par_ok;
          ferr_set = ~(rxs_q & par_ok);
        end
      end
      default: state_d = IDLE;
    endcase
    mem_d = mem_q;
    if (do_push) mem_d[wp_q[AW-1:0]] = sh_q;
    wp_d = do_push ? wp_q + (AW+1)'(1) : wp_q;
    rp_d = pop ? rp_q + (AW+1)'(1) : rp_q;
    // a new error in the same cycle as err_clr keeps the flag set
    frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    overrun_err_d = (push & full & ~pop) | (overrun_err_q & ~err_clr);
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      s1_q <= 1'b1;
      rxs_q <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q <= IDLE;
      bcnt_q <= 16'd0;
      cnt_q <= '0;
      bit_q <= 3'd0;
      sh_q <= 8'd0;
      wp_q <= '0;
      rp_q <= '0;
      mem_q <= '{default: 8'd0};
      frame_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      s1_q <= uart_rx;
      rxs_q <= s1_q;
      rxs_prev_q <= rxs_q;
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      mem_q <= mem_d;
      frame_err_q <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_krv_uart_rx.sv
// tb_krv_uart_rx: directed and randomized frames checked against a queue-based receiver model.
module tb_krv_uart_rx;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // edge index (counted from the first edge after the start bit is driven) of the mid-stop sample
  localparam int SE = 26 + 16 * (NB - 2);
  logic clk = 1'b0;
  logic rst, uart_rx, rx_ready, err_clr;
  logic [15:0] baud_div;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun_err, rx_busy;
  int ncmp = 0;
  int nfail = 0;
  logic [7:0] exp_q [$];
  logic m_ferr = 1'b0;
  logic m_ovr = 1'b0;
  always #5 clk = ~clk;
  krv_uart_rx #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16)) dut (
    .cpu_clk(clk), .cpu_rst(rst), .uart_rx(uart_rx), .baud_div(baud_div),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .err_clr(err_clr), .rx_busy(rx_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, "_data"}, 32'(rx_data), 32'(exp_q[0]));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_ovr"}, 32'(overrun_err), 32'(m_ovr));
    chk({tag, "_busy"}, 32'(rx_busy), 32'(0));
  endtask
  task automatic pop_one(input string tag);
    chk({tag, "_head"}, 32'(rx_data), 32'(exp_q[0]));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask
  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask
  // mode 0: plain frame; 1: check rx_valid around the mid-stop edge; 2: pop on the mid-stop edge
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip, input int mode);
    logic [10:0] bits;
    int len;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ par_flip;
    bits[10] = stop_b;
`else
    bits[9] = stop_b;
`endif
    len = 16 * (int'(baud_div) + 1);
    for (int i = 0; i < NB * len; i++) begin
      uart_rx = bits[i / len];
      if (mode == 1 && i == SE) chk("pre_stop_valid", 32'(rx_valid), 32'(0));
      if (mode == 1 && i == SE + 1) chk("post_stop_valid", 32'(rx_valid), 32'(1));
      if (mode == 2) rx_ready = (i == SE);
      @(negedge clk);
    end
    uart_rx = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    if (mode == 2 && exp_q.size() != 0) void'(exp_q.pop_front());
    if (stop_b && !par_flip) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_ovr = 1'b1;
    end else m_ferr = 1'b1;
  endtask
  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    baud_div = 16'd0;
    rx_ready = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'(0));
    chk("rst_data", 32'(rx_data), 32'(0));
    chk("rst_ferr", 32'(frame_err), 32'(0));
    chk("rst_ovr", 32'(overrun_err), 32'(0));
    chk("rst_busy", 32'(rx_busy), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hA5, 1'b1, 1'b0, 1);
    check_all("single");
    pop_one("single_pop");
    check_all("single_after_pop");
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", 32'(rx_busy), 32'(1));
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check_all("glitch");
    send(8'h3C, 1'b0, 1'b0, 0);
    check_all("frame_err");
    clear_errs();
    check_all("frame_err_clr");
    send(8'h3C, 1'b1, 1'b0, 0);
    check_all("after_ferr");
    pop_one("after_ferr_pop");
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 0);
    chk("ovr_count", 32'(exp_q.size()), 32'(DEPTH));
    check_all("overrun");
    clear_errs();
    send(8'h06, 1'b1, 1'b0, 2);
    check_all("full_pop_push");
    while (exp_q.size() != 0) pop_one("drain");
    check_all("drained");
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 0);
    check_all("par_good");
    send(8'h07, 1'b1, 1'b1, 0);
    check_all("par_bad");
    pop_one("par_pop");
    clear_errs();
`endif
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic stop_b, pf;
      baud_div = 16'($urandom_range(0, 3));
      d = 8'($urandom);
      stop_b = $urandom_range(0, 4) != 0;
`ifdef UART_RX_PARITY_EN
      pf = $urandom_range(0, 5) == 0;
`else
      pf = 1'b0;
`endif
      send(d, stop_b, pf, 0);
      check_all("rand");
      for (int k = $urandom_range(0, 2); k > 0 && exp_q.size() != 0; k--) pop_one("rand_pop");
      if ($urandom_range(0, 5) == 0) clear_errs();
    end
    baud_div = 16'd0;
    if (exp_q.size() == 0) send(8'h5A, 1'b1, 1'b0, 0);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("midframe_busy", 32'(rx_busy), 32'(1));
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    repeat (4) @(negedge clk);
    check_all("midframe_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
